// File: rtl/vx_sideband_stash.sv
// Strips an S-bit sideband field from each request, parks it in an in-order FIFO,
// and splices the oldest parked field back into each returning response.
module vx_sideband_stash #(
  parameter int REQ_N   = 32,
  parameter int RSP_N   = 32,
  parameter int S       = 4,
  parameter int REQ_POS = 0,
  parameter int RSP_POS = 0,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_in_valid,
  input  logic [REQ_N+S-1:0]       req_in_data,
  output logic                     req_in_ready,
  output logic                     req_out_valid,
  output logic [REQ_N-1:0]         req_out_data,
  input  logic                     req_out_ready,
  input  logic                     rsp_in_valid,
  input  logic [RSP_N-1:0]         rsp_in_data,
  output logic                     rsp_in_ready,
  output logic                     rsp_out_valid,
  output logic [RSP_N+S-1:0]       rsp_out_data,
  input  logic                     rsp_out_ready,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     stash_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = REQ_N + S;
  localparam int OW = RSP_N + S;

  if (S < 1) begin : g_bad_s
    $error("vx_sideband_stash: S must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("vx_sideband_stash: DEPTH must be a power of 2 and >= 2");
  end

  logic             req_out_valid_q, req_out_valid_d;
  logic [REQ_N-1:0] req_out_data_q, req_out_data_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [S-1:0]     stash_q [DEPTH];

  logic             pipe_ready, non_empty, push, pop;
  logic [IW-1:0]    req_mask, req_low, req_high;
  logic [REQ_N-1:0] req_stripped;
  logic [S-1:0]     req_field, head_field;
  logic [OW-1:0]    rsp_wide, rsp_mask;

  // Field removal/insertion via masks and shifts so REQ_POS/RSP_POS may sit at either end.
  always_comb begin
    req_mask     = (IW'(1) << REQ_POS) - IW'(1);
    req_low      = req_in_data & req_mask;
    req_high     = (req_in_data >> (REQ_POS + S)) << REQ_POS;
    req_stripped = REQ_N'(req_low | req_high);
    req_field    = S'(req_in_data >> REQ_POS);
  end

  assign head_field = stash_q[rd_ptr_q];

  always_comb begin
    rsp_wide     = OW'(rsp_in_data);
    rsp_mask     = (OW'(1) << RSP_POS) - OW'(1);
    rsp_out_data = ((rsp_wide & ~rsp_mask) << S) | (OW'(head_field) << RSP_POS)
                 | (rsp_wide & rsp_mask);
  end

  assign stash_full    = (count_q == CW'(DEPTH));
  assign non_empty     = (count_q != '0);
  assign pipe_ready    = !req_out_valid_q || req_out_ready;
  assign req_in_ready  = pipe_ready && !stash_full;
  assign push          = req_in_valid && req_in_ready;
  assign rsp_out_valid = rsp_in_valid && non_empty;
  assign rsp_in_ready  = rsp_out_ready && non_empty;
  assign pop           = rsp_in_valid && rsp_in_ready;

  assign req_out_valid = req_out_valid_q;
  assign req_out_data  = req_out_data_q;
  assign outstanding   = count_q;

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    req_out_valid_d = req_out_valid_q;
    req_out_data_d  = req_out_data_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    if (pipe_ready) req_out_valid_d = push;
    if (push) begin
      req_out_data_d = req_stripped;
      wr_ptr_d       = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_out_valid_q <= 1'b0;
      req_out_data_q  <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      req_out_valid_q <= req_out_valid_d;
      req_out_data_q  <= req_out_data_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  // NOTE: the field storage is not reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) stash_q[wr_ptr_q] <= req_field;
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) pop |-> non_empty);
  a_no_push_full: assert property (@(posedge clk) disable iff (reset) push |-> !stash_full);

endmodule

// File: tb/tb_vx_sideband_stash.sv
// Directed bench for vx_sideband_stash (REQ_POS=4, RSP_POS=0, S=4, DEPTH=4):
// a per-cycle vector table plus hand-written stall and reset sequences.
module tb_vx_sideband_stash;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_in_valid;
  logic [35:0] req_in_data;
  logic        req_in_ready;
  logic        req_out_valid;
  logic [31:0] req_out_data;
  logic        req_out_ready;
  logic        rsp_in_valid;
  logic [31:0] rsp_in_data;
  logic        rsp_in_ready;
  logic        rsp_out_valid;
  logic [35:0] rsp_out_data;
  logic        rsp_out_ready;
  logic [2:0]  outstanding;
  logic        stash_full;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vx_sideband_stash #(
    .REQ_N(32), .RSP_N(32), .S(4), .REQ_POS(4), .RSP_POS(0), .DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_in_valid(req_in_valid), .req_in_data(req_in_data), .req_in_ready(req_in_ready),
    .req_out_valid(req_out_valid), .req_out_data(req_out_data), .req_out_ready(req_out_ready),
    .rsp_in_valid(rsp_in_valid), .rsp_in_data(rsp_in_data), .rsp_in_ready(rsp_in_ready),
    .rsp_out_valid(rsp_out_valid), .rsp_out_data(rsp_out_data), .rsp_out_ready(rsp_out_ready),
    .outstanding(outstanding), .stash_full(stash_full)
  );

  typedef struct {
    logic        riv;
    logic [35:0] rid;
    logic        ror;
    logic        siv;
    logic [31:0] sid;
    logic        sor;
    logic        e_rir;
    logic        e_rov;
    logic [31:0] e_rod;
    logic        e_sov;
    logic        e_sir;
    logic        chk_sod;
    logic [35:0] e_sod;
    logic [2:0]  e_out;
    logic        e_full;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic riv, input logic [35:0] rid, input logic ror,
                        input logic siv, input logic [31:0] sid, input logic sor);
    req_in_valid  = riv;
    req_in_data   = rid;
    req_out_ready = ror;
    rsp_in_valid  = siv;
    rsp_in_data   = sid;
    rsp_out_ready = sor;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    check($sformatf("v%0d req_in_ready", i),  64'(req_in_ready),  64'(v.e_rir));
    check($sformatf("v%0d req_out_valid", i), 64'(req_out_valid), 64'(v.e_rov));
    check($sformatf("v%0d req_out_data", i),  64'(req_out_data),  64'(v.e_rod));
    check($sformatf("v%0d rsp_out_valid", i), 64'(rsp_out_valid), 64'(v.e_sov));
    check($sformatf("v%0d rsp_in_ready", i),  64'(rsp_in_ready),  64'(v.e_sir));
    if (v.chk_sod) check($sformatf("v%0d rsp_out_data", i), 64'(rsp_out_data), 64'(v.e_sod));
    check($sformatf("v%0d outstanding", i),   64'(outstanding),   64'(v.e_out));
    check($sformatf("v%0d stash_full", i),    64'(stash_full),    64'(v.e_full));
  endtask

  initial begin
    logic [3:0]  tags [3];
    logic [31:0] sid;

    // riv rid ror siv sid sor | rir rov rod sov sir chk sod out full
    vecs[0]  = '{1'b1, 36'h0_0000_0A53, 1'b1, 1'b0, 32'h0, 1'b1,
                 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 36'h0, 3'd0, 1'b0};
    vecs[1]  = '{1'b0, 36'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1,
                 1'b1, 1'b1, 32'hA3,  1'b1, 1'b1, 1'b1, 36'hD_EADB_EEF5, 3'd1, 1'b0};
    vecs[2]  = '{1'b0, 36'h0, 1'b1, 1'b0, 32'h0, 1'b1,
                 1'b1, 1'b0, 32'hA3,  1'b0, 1'b0, 1'b0, 36'h0, 3'd0, 1'b0};
    vecs[3]  = '{1'b1, 36'h0_0000_0B11, 1'b1, 1'b0, 32'h0, 1'b1,
                 1'b1, 1'b0, 32'hA3,  1'b0, 1'b0, 1'b0, 36'h0, 3'd0, 1'b0};
    vecs[4]  = '{1'b1, 36'h0_0000_0B22, 1'b1, 1'b0, 32'h0, 1'b1,
                 1'b1, 1'b1, 32'hB1,  1'b0, 1'b1, 1'b0, 36'h0, 3'd1, 1'b0};
    vecs[5]  = '{1'b1, 36'h0_0000_0B33, 1'b1, 1'b0, 32'h0, 1'b1,
                 1'b1, 1'b1, 32'hB2,  1'b0, 1'b1, 1'b0, 36'h0, 3'd2, 1'b0};
    vecs[6]  = '{1'b1, 36'h0_0000_0B44, 1'b1, 1'b0, 32'h0, 1'b1,
                 1'b1, 1'b1, 32'hB3,  1'b0, 1'b1, 1'b0, 36'h0, 3'd3, 1'b0};
    vecs[7]  = '{1'b1, 36'h0_0000_0B66, 1'b1, 1'b0, 32'h0, 1'b1,
                 1'b0, 1'b1, 32'hB4,  1'b0, 1'b1, 1'b0, 36'h0, 3'd4, 1'b1};
    vecs[8]  = '{1'b1, 36'h0_0000_0B66, 1'b1, 1'b0, 32'h0, 1'b1,
                 1'b0, 1'b0, 32'hB4,  1'b0, 1'b1, 1'b0, 36'h0, 3'd4, 1'b1};
    // full: pop and req_in_valid together must not push
    vecs[9]  = '{1'b1, 36'h0_0000_0B66, 1'b1, 1'b1, 32'h1111_0000, 1'b1,
                 1'b0, 1'b0, 32'hB4,  1'b1, 1'b1, 1'b1, 36'h1_1110_0001, 3'd4, 1'b1};
    vecs[10] = '{1'b1, 36'h0_0000_0B66, 1'b1, 1'b0, 32'h0, 1'b1,
                 1'b1, 1'b0, 32'hB4,  1'b0, 1'b1, 1'b0, 36'h0, 3'd3, 1'b0};
    vecs[11] = '{1'b0, 36'h0, 1'b1, 1'b1, 32'h2222_0000, 1'b1,
                 1'b0, 1'b1, 32'hB6,  1'b1, 1'b1, 1'b1, 36'h2_2220_0002, 3'd4, 1'b1};
    vecs[12] = '{1'b0, 36'h0, 1'b1, 1'b1, 32'h3333_0000, 1'b1,
                 1'b1, 1'b0, 32'hB6,  1'b1, 1'b1, 1'b1, 36'h3_3330_0003, 3'd3, 1'b0};
    vecs[13] = '{1'b0, 36'h0, 1'b1, 1'b1, 32'h4444_0000, 1'b1,
                 1'b1, 1'b0, 32'hB6,  1'b1, 1'b1, 1'b1, 36'h4_4440_0004, 3'd2, 1'b0};
    vecs[14] = '{1'b0, 36'h0, 1'b1, 1'b1, 32'h5555_0000, 1'b1,
                 1'b1, 1'b0, 32'hB6,  1'b1, 1'b1, 1'b1, 36'h5_5550_0006, 3'd1, 1'b0};
    vecs[15] = '{1'b0, 36'h0, 1'b1, 1'b1, 32'h6666_0000, 1'b1,
                 1'b1, 1'b0, 32'hB6,  1'b0, 1'b0, 1'b0, 36'h0, 3'd0, 1'b0};

    // Reset with a response already waiting: it must stay stalled.
    reset = 1'b1;
    set_in(1'b0, 36'h0, 1'b1, 1'b1, 32'h7777_0000, 1'b1);
    #2;
    check("rst req_out_valid", 64'(req_out_valid), 64'd0);
    check("rst req_out_data",  64'(req_out_data),  64'd0);
    check("rst outstanding",   64'(outstanding),   64'd0);
    check("rst stash_full",    64'(stash_full),    64'd0);
    check("rst rsp_out_valid", 64'(rsp_out_valid), 64'd0);
    check("rst rsp_in_ready",  64'(rsp_in_ready),  64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel rsp_in_ready", 64'(rsp_in_ready), 64'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      set_in(vecs[i].riv, vecs[i].rid, vecs[i].ror, vecs[i].siv, vecs[i].sid, vecs[i].sor);
      #1;
      check_vec(i, vecs[i]);
    end

    // Downstream stall: one push, output held, then one request per cycle.
    @(negedge clk);
    set_in(1'b1, 36'h0_0000_0C77, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    check("stall first ready", 64'(req_in_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_in_data = 36'h0_0000_0C88;
      #1;
      check($sformatf("stall%0d req_in_ready", k), 64'(req_in_ready), 64'd0);
      check($sformatf("stall%0d req_out_data", k), 64'(req_out_data), 64'hC7);
      check($sformatf("stall%0d outstanding", k),  64'(outstanding),  64'd1);
    end
    @(negedge clk);
    req_out_ready = 1'b1;
    #1;
    check("release req_in_ready", 64'(req_in_ready), 64'd1);
    check("release req_out_data", 64'(req_out_data), 64'hC7);
    @(negedge clk);
    req_in_data = 36'h0_0000_0C99;
    #1;
    check("flow1 req_out_data", 64'(req_out_data), 64'hC8);
    check("flow1 outstanding",  64'(outstanding),  64'd2);
    @(negedge clk);
    req_in_valid = 1'b0;
    #1;
    check("flow2 req_out_data", 64'(req_out_data), 64'hC9);
    check("flow2 outstanding",  64'(outstanding),  64'd3);
    @(negedge clk);
    #1;
    check("flow3 req_out_valid", 64'(req_out_valid), 64'd0);
    tags = '{4'h7, 4'h8, 4'h9};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sid = 32'hA000_0000 + 32'(k);
      rsp_in_valid = 1'b1;
      rsp_in_data  = sid;
      #1;
      check($sformatf("drain%0d rsp_out_data", k), 64'(rsp_out_data), 64'({sid, tags[k]}));
    end
    @(negedge clk);
    rsp_in_valid = 1'b0;
    #1;
    check("drained outstanding", 64'(outstanding), 64'd0);

    // Reset mid-burst discards parked fields and the held request.
    @(negedge clk);
    set_in(1'b1, 36'h0_0000_0DAA, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    req_in_data = 36'h0_0000_0DBB;
    req_out_ready = 1'b1;
    @(negedge clk);
    req_in_data  = 36'h0_0000_0DEE;
    rsp_in_valid = 1'b1;
    rsp_in_data  = 32'hBBBB_0000;
    rsp_out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("midrst req_out_valid", 64'(req_out_valid), 64'd0);
    check("midrst req_out_data",  64'(req_out_data),  64'd0);
    check("midrst outstanding",   64'(outstanding),   64'd0);
    check("midrst stash_full",    64'(stash_full),    64'd0);
    check("midrst rsp_out_valid", 64'(rsp_out_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    req_in_valid  = 1'b0;
    rsp_out_ready = 1'b1;
    #1;
    check("post rsp_in_ready a", 64'(rsp_in_ready), 64'd0);
    @(negedge clk);
    #1;
    check("post rsp_in_ready b", 64'(rsp_in_ready), 64'd0);
    @(negedge clk);
    req_in_valid = 1'b1;
    req_in_data  = 36'h0_0000_0DCC;
    #1;
    check("nobypass rsp_in_ready", 64'(rsp_in_ready), 64'd0);
    check("nobypass req_in_ready", 64'(req_in_ready), 64'd1);
    @(negedge clk);
    req_in_valid = 1'b0;
    #1;
    check("late rsp_in_ready",  64'(rsp_in_ready),  64'd1);
    check("late rsp_out_valid", 64'(rsp_out_valid), 64'd1);
    check("late rsp_out_data",  64'(rsp_out_data),  64'h0_BBBB_0000C);
    check("late req_out_data",  64'(req_out_data),  64'hDC);
    @(negedge clk);
    rsp_in_valid = 1'b0;
    #1;
    check("final outstanding", 64'(outstanding), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
